// File: rtl/frame_feeder_pkg.sv
// Shared types for the frame feeder: FSM state encoding and the FIFO entry layout.
package frame_feeder_pkg;

    localparam int FF_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } feeder_state_t;

    // Entry layout at the default sample width; the top builds the same shape at its own W.
    typedef struct packed {
        logic            last;
        logic [FF_W-1:0] data;
    } ff_entry_t;

endpackage

// File: rtl/frame_feeder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; exposes full, empty and fill count.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/frame_feeder.sv
// Buffers a valid/ready sample stream and replays each complete frame as a contiguous burst.
// Optional macro FRAME_FEEDER_STATS_EN enables the frames_sent burst counter.
//
// state  | meaning
// IDLE   | waiting for a complete frame in the FIFO
// STREAM | popping one sample per cycle, start high
// GAP    | one start-low cycle after the last sample of a burst
module frame_feeder
    import frame_feeder_pkg::*;
#(
    parameter int W         = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_FRAME = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         start,
    output logic [W-1:0] data_out,
    output logic         busy,
    output logic         trunc_err,
    output logic [15:0]  frames_sent
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } entry_t;

    feeder_state_t state, state_nxt;
    entry_t        wr_entry, rd_entry;
    logic          fifo_full, fifo_empty;
    logic          push, pop, forced_last;
    logic          start_nxt;
    logic [W-1:0]  data_nxt;
    logic [CW-1:0] fill, frame_cnt, pend_frames;

    // Readiness follows the fill level before this cycle's pop; no bypass.
    assign in_ready      = (fill < CW'(DEPTH));
    assign push          = in_valid && !fifo_full;
    assign forced_last   = (frame_cnt == CW'(MAX_FRAME - 1));
    assign wr_entry.last = in_last | forced_last;
    assign wr_entry.data = in_data;
    assign busy          = (state != IDLE);

    sync_fifo #(
        .WIDTH(W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt   <= '0;
            pend_frames <= '0;
            trunc_err   <= 1'b0;
        end else begin
            if (push)
                frame_cnt <= wr_entry.last ? '0 : frame_cnt + 1'b1;
            if (push && forced_last && !in_last)
                trunc_err <= 1'b1;
            case ({push && wr_entry.last, pop && rd_entry.last})
                2'b10:   pend_frames <= pend_frames + 1'b1;
                2'b01:   pend_frames <= pend_frames - 1'b1;
                default: pend_frames <= pend_frames;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start_nxt = 1'b0;
        data_nxt  = '0;
        unique case (state)
            IDLE: begin
                if (pend_frames != '0)
                    state_nxt = STREAM;
            end
            STREAM: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    start_nxt = 1'b1;
                    data_nxt  = rd_entry.data;
                    if (rd_entry.last)
                        state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            start    <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nxt;
            start    <= start_nxt;
            data_out <= data_nxt;
        end
    end

`ifdef FRAME_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            frames_sent <= '0;
        else if (pop && rd_entry.last)
            frames_sent <= frames_sent + 16'd1;
    end
`else
    assign frames_sent = '0;
`endif

endmodule
